// File: rtl/bcd_alu_seq.sv
// bcd_alu_seq: signed BCD accumulator ALU with edge-qualified key capture and a digit-serial add/subtract engine
module bcd_alu_seq #(
  parameter int         DIGITS    = 10,
  parameter logic [3:0] IDLE_CODE = 4'hD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_ALU,
  input  logic [3:0]            digit,
  input  logic [1:0]            operation,
  output logic [4*DIGITS-1:0]   AUX,
  output logic                  sgn_AUX,
  output logic                  full_AUX,
  output logic                  full_ACC,
  output logic                  busy,
  output logic                  done
);
  localparam int W = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS);
  localparam logic [1:0] OP_NONE = 2'b00, OP_ADD = 2'b01, OP_SUB = 2'b10, OP_EQ = 2'b11;
  typedef enum logic [1:0] {ENTRY, EXEC_A, EXEC_B, WRITE} state_t;
  state_t state, state_d;
  logic [W-1:0] acc, opa, opb, res, res_n;
  logic [1:0] pending, nxt_op, prev_op;
  logic [3:0] prev_digit, dig;
  logic [CW-1:0] cnt;
  logic [4:0] sum;
  logic acc_sgn, res_sgn, sub, cy, cy_n, fresh, has_digits, lead, d_ev, o_ev, start, last;
  assign o_ev = state == ENTRY && operation != OP_NONE && prev_op == OP_NONE;
  assign d_ev = state == ENTRY && !o_ev && digit <= 4'd9 && prev_digit == IDLE_CODE;
  assign start = o_ev && has_digits && pending != OP_NONE;
  assign last = cnt == CW'(DIGITS - 1);
  assign busy = state == EXEC_A || state == EXEC_B;
  // one BCD digit per cycle; subtraction adds the 9s complement with an initial carry of 1
  assign sum = {1'b0, opa[3:0]} + {1'b0, sub ? 4'd9 - opb[3:0] : opb[3:0]} + {4'b0, cy};
  assign cy_n = sum > 5'd9;
  assign dig = cy_n ? 4'(sum - 5'd10) : sum[3:0];
  assign res_n = {dig, res[W-1:4]};
  // next state: a final borrow in pass A sends the result through a 10s-complement pass
  always_comb begin
    state_d = state;
    if (clear_ALU) state_d = ENTRY;
    else if (state == ENTRY) state_d = start ? EXEC_A : ENTRY;
    else if (state == EXEC_A) state_d = !last ? EXEC_A : (sub && !cy_n) ? EXEC_B : WRITE;
    else if (state == EXEC_B) state_d = last ? WRITE : EXEC_B;
    else state_d = ENTRY;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ENTRY;
    else state <= state_d;
  end
  // key capture, operand entry, engine datapath and result write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      AUX <= '0; sgn_AUX <= 1'b0; full_AUX <= 1'b0; full_ACC <= 1'b0; done <= 1'b0;
      acc <= '0; acc_sgn <= 1'b0; pending <= OP_NONE; fresh <= 1'b1; has_digits <= 1'b0;
      lead <= 1'b0; prev_digit <= IDLE_CODE; prev_op <= OP_NONE;
      opa <= '0; opb <= '0; res <= '0; cnt <= '0; cy <= 1'b0; sub <= 1'b0;
      res_sgn <= 1'b0; nxt_op <= OP_NONE;
    end else if (clear_ALU) begin
      AUX <= '0; sgn_AUX <= 1'b0; full_AUX <= 1'b0; full_ACC <= 1'b0; done <= 1'b0;
      acc <= '0; acc_sgn <= 1'b0; pending <= OP_NONE; fresh <= 1'b1; has_digits <= 1'b0;
      lead <= 1'b0; prev_digit <= IDLE_CODE; prev_op <= OP_NONE;
    end else begin
      prev_digit <= digit;
      prev_op <= operation;
      done <= 1'b0;
      if (state == ENTRY) begin
        if (o_ev) begin
          full_AUX <= 1'b0;
          if (has_digits && pending == OP_NONE) begin
            acc <= AUX;
            acc_sgn <= sgn_AUX;
            pending <= operation == OP_EQ ? OP_NONE : operation;
            has_digits <= operation == OP_EQ;
            fresh <= 1'b1;
            lead <= 1'b0;
          end else if (start) begin
            opa <= acc;
            opb <= AUX;
            sub <= acc_sgn != (sgn_AUX ^ (pending == OP_SUB));
            cy <= acc_sgn != (sgn_AUX ^ (pending == OP_SUB));
            res_sgn <= acc_sgn;
            nxt_op <= operation == OP_EQ ? OP_NONE : operation;
            cnt <= '0;
          end else if (operation != OP_EQ) begin
            if (pending == OP_NONE) begin
              sgn_AUX <= operation == OP_SUB;
              lead <= operation == OP_SUB;
            end else pending <= operation;
          end
        end else if (d_ev) begin
          if (fresh) begin
            AUX <= {{(W-4){1'b0}}, digit};
            sgn_AUX <= lead;
            fresh <= 1'b0;
            has_digits <= 1'b1;
          end else if (AUX[W-1:W-4] == 4'd0) AUX <= {AUX[W-5:0], digit};
          else full_AUX <= 1'b1;
        end
      end else if (state != WRITE) begin
        opa <= opa >> 4;
        opb <= opb >> 4;
        res <= res_n;
        cy <= cy_n;
        cnt <= last ? '0 : cnt + 1'b1;
        if (state == EXEC_A && last && !sub && cy_n) full_ACC <= 1'b1;
        if (state == EXEC_A && last && sub && !cy_n) begin
          opa <= '0;
          opb <= res_n;
          cy <= 1'b1;
          res_sgn <= !res_sgn;
        end
      end else begin
        AUX <= res;
        sgn_AUX <= res_sgn && res != '0;
        acc <= res;
        acc_sgn <= res_sgn && res != '0;
        done <= 1'b1;
        fresh <= 1'b1;
        pending <= nxt_op;
        has_digits <= nxt_op == OP_NONE;
        lead <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_bcd_alu_seq.sv
// tb_bcd_alu_seq: scoreboard bench for the signed BCD accumulator ALU
module tb_bcd_alu_seq;
  localparam int D = 10;
  localparam int W = 4 * D;
  localparam logic [3:0] IDLE = 4'hD;
  logic clk = 1'b0, rst_n = 1'b0, clear_alu = 1'b0, clear4 = 1'b0;
  logic [3:0] digit = IDLE, digit4 = IDLE;
  logic [1:0] operation = 2'b00, op4 = 2'b00;
  logic [W-1:0] aux;
  logic [15:0] aux4;
  logic sgn, full_aux, full_acc, busy, done, sgn4, fa4, fc4, busy4, done4;
  int checks = 0, failures = 0, cyc = 0, busy_cnt = 0, done_cnt = 0;
  bit busy_prev = 1'b0;
  typedef struct {logic [W-1:0] aux; logic sgn; logic facc; int lat; int bc; int t0;} exp_t;
  exp_t q[$];
  exp_t e;

  bcd_alu_seq #(.DIGITS(D), .IDLE_CODE(IDLE)) dut (
    .clk(clk), .rst_n(rst_n), .clear_ALU(clear_alu), .digit(digit), .operation(operation),
    .AUX(aux), .sgn_AUX(sgn), .full_AUX(full_aux), .full_ACC(full_acc), .busy(busy), .done(done)
  );
  bcd_alu_seq #(.DIGITS(4), .IDLE_CODE(IDLE)) dut4 (
    .clk(clk), .rst_n(rst_n), .clear_ALU(clear4), .digit(digit4), .operation(op4),
    .AUX(aux4), .sgn_AUX(sgn4), .full_AUX(fa4), .full_ACC(fc4), .busy(busy4), .done(done4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input longint v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // scoreboard: every done pulse pops one expected result
  always @(negedge clk) begin
    if (busy) busy_cnt = busy_prev ? busy_cnt + 1 : 1;
    busy_prev = busy;
    if (done) begin
      done_cnt++;
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = q.pop_front();
        chk("aux", aux, e.aux);
        chk("sgn", sgn, e.sgn);
        chk("full_acc", full_acc, e.facc);
        chk("latency", cyc - e.t0, e.lat);
        chk("busy_cycles", busy_cnt, e.bc);
      end
    end
  end

  task automatic key(input logic [3:0] d, input int hold, input bit u4);
    @(negedge clk);
    if (u4) digit4 = d; else digit = d;
    repeat (hold - 1) @(negedge clk);
    @(negedge clk);
    if (u4) digit4 = IDLE; else digit = IDLE;
  endtask

  task automatic num(input int v, input bit u4);
    string s = $sformatf("%0d", v);
    for (int i = 0; i < s.len(); i++) key(4'(s[i] - 8'd48), 1, u4);
  endtask

  task automatic opk(input logic [1:0] o, input bit u4);
    @(negedge clk);
    if (u4) op4 = o; else operation = o;
    @(negedge clk);
    if (u4) op4 = 2'b00; else operation = 2'b00;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic s, input logic f,
                        input int lat, input int bc);
    @(negedge clk);
    operation = o;
    q.push_back('{a, s, f, lat, bc, cyc});
    @(negedge clk);
    operation = 2'b00;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (q.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk(tag, q.size(), 0);
    q.delete();
  endtask

  task automatic wait4(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = done4;
    end
    chk(tag, seen, 1);
  endtask

  task automatic clr(input bit u4);
    @(negedge clk);
    if (u4) clear4 = 1'b1; else clear_alu = 1'b1;
    @(negedge clk);
    if (u4) clear4 = 1'b0; else clear_alu = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, dc;
    logic [1:0] o;
    longint r;
    bit brw;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_aux", aux, 0);
    chk("rst_sgn", sgn, 0);
    chk("rst_full_aux", full_aux, 0);
    chk("rst_full_acc", full_acc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    opk(2'b10, 0);
    num(35, 0);
    chk("entry_aux", aux, 40'h35);
    chk("entry_sgn", sgn, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_aux", aux, 0);
    chk("async_rst_sgn", sgn, 0);
    @(negedge clk);
    rst_n = 1'b1;
    num(46, 0); opk(2'b01, 0); num(70, 0);
    run_op(2'b11, 40'h116, 0, 0, 12, 10);
    wait_done("add_46_70");
    clr(0);
    opk(2'b10, 0); num(88, 0); opk(2'b10, 0); num(212, 0);
    run_op(2'b11, 40'h300, 1, 0, 12, 10);
    wait_done("neg88_minus_212");
    clr(0);
    num(16, 0); opk(2'b10, 0); num(185, 0);
    run_op(2'b11, 40'h169, 1, 0, 22, 20);
    wait_done("16_minus_185");
    clr(0);
    opk(2'b10, 0); num(9, 0); opk(2'b01, 0); num(564, 0);
    run_op(2'b11, 40'h555, 0, 0, 22, 20);
    wait_done("neg9_plus_564");
    key(4'd5, 5, 0);
    chk("held_key_once", aux, 40'h5);
    key(4'd2, 1, 0);
    chk("after_held_key", aux, 40'h52);
    clr(0);
    num(5, 0); opk(2'b01, 0); num(3, 0);
    run_op(2'b10, 40'h8, 0, 0, 12, 10);
    wait_done("chain_5_plus_3");
    opk(2'b01, 0); num(2, 0);
    run_op(2'b11, 40'h10, 0, 0, 12, 10);
    wait_done("chain_replace_pending");
    clr(0);
    opk(2'b10, 0); num(7, 0); opk(2'b01, 0); num(7, 0);
    run_op(2'b11, 40'h0, 0, 0, 12, 10);
    wait_done("zero_result_positive");
    clr(0);
    repeat (10) key(4'd9, 1, 0);
    key(4'd4, 1, 0);
    chk("aux_full_value", aux, 40'h9999999999);
    chk("aux_full_flag", full_aux, 1);
    opk(2'b01, 0);
    chk("aux_full_cleared", full_aux, 0);
    num(9, 0);
    run_op(2'b11, 40'h8, 0, 1, 12, 10);
    wait_done("acc_overflow");
    clr(0);
    chk("clear_full_acc", full_acc, 0);
    num(2, 0); opk(2'b01, 0); num(3, 0);
    run_op(2'b11, 40'h5, 0, 0, 12, 10);
    key(4'd7, 1, 0);
    opk(2'b01, 0);
    wait_done("busy_drop");
    repeat (2) @(negedge clk);
    chk("busy_drop_aux", aux, 40'h5);
    key(4'd4, 1, 0);
    chk("new_expr_after_eq", aux, 40'h4);
    clr(0);
    num(1, 0); opk(2'b01, 0); num(2, 0); opk(2'b11, 0);
    repeat (3) @(negedge clk);
    dc = done_cnt;
    clr(0);
    chk("abort_aux", aux, 0);
    chk("abort_busy", busy, 0);
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_cnt - dc, 0);
    for (int i = 0; i < 6; i++) begin
      clr(0);
      a = int'($urandom_range(0, 999999));
      b = int'($urandom_range(0, 999999));
      o = 2'($urandom_range(1, 2));
      num(a, 0); opk(o, 0); num(b, 0);
      r = (o == 2'b01) ? longint'(a) + longint'(b) : longint'(a) - longint'(b);
      brw = o == 2'b10 && a < b;
      run_op(2'b11, to_bcd(r < 0 ? -r : r), r < 0, 0, brw ? 22 : 12, brw ? 20 : 10);
      wait_done("random_expr");
    end
    num(9999, 1); opk(2'b01, 1); num(1, 1); opk(2'b11, 1);
    wait4("d4_done");
    chk("d4_aux_wrap", aux4, 16'h0000);
    chk("d4_full_acc", fc4, 1);
    clr(1);
    num(12, 1); opk(2'b10, 1); num(345, 1); opk(2'b11, 1);
    wait4("d4_sub_done");
    chk("d4_sub_aux", aux4, 16'h0333);
    chk("d4_sub_sgn", sgn4, 1);
    chk("d4_sub_full_acc", fc4, 0);
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bcd_alu_seq.md
Name: bcd_alu_seq

Overview:
Parametrised signed BCD accumulator ALU for the calculator datapath. It is the successor to the fixed 10-digit ALU, with digit count set by parameter. It adds edge-qualified key capture, chained +/- operations and a digit-serial add/subtract engine with a busy/done handshake. It sits between the keypad decoder (digit/operation codes) and the display driver (AUX, sgn_AUX, overflow flags).

Parameters:
DIGITS, 10, number of BCD digits in AUX and ACC (≥2)
IDLE_CODE, 4'hD, digit code meaning "no key pressed"

Ports:
clk  in  1  system clock (12 MHz)
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
clear_ALU  in  1  synchronous clear, highest priority after rst_n
digit  in  4  key code; 0-9 digits, IDLE_CODE idle, others ignored
operation  in  2  00 none, 01 '+', 10 '-', 11 '='
AUX  out  4*DIGITS  BCD display register, digit 0 in [3:0]
sgn_AUX  out  1  sign of AUX, 1 = negative
full_AUX  out  1  sticky, digit entry rejected (AUX full)
full_ACC  out  1  sticky, result magnitude overflowed 10^DIGITS
busy  out  1  execution engine running
done  out  1  one-cycle pulse, result written to AUX

Behaviour:
- Reset (rst_n low, async) and clear_ALU (sync): AUX=0, sgn_AUX=0, full_AUX=0, full_ACC=0, busy=0, done=0, ACC=0, pending op=none, state ENTRY, fresh=1, prev_digit=IDLE_CODE, prev_op=00. clear_ALU aborts execution mid-run with no partial write.
- Digit event: digit≤9 and registered prev_digit==IDLE_CODE. Holding a key gives one event. Codes 10-15 never generate events.
- Op event: operation!=00 and prev_op==00. prev_digit and prev_op update every cycle, including while busy.
- Events arriving while busy=1 are dropped.
- States: ENTRY, EXEC_A (pass 1), EXEC_B (complement pass), WRITE.
- Digit event in ENTRY:
  - If fresh: AUX={0..,d}, fresh=0, operand_has_digits=1.
  - Else if top nibble of AUX is 0: shift AUX left one nibble and insert d.
  - Else: reject, full_AUX=1.
- Leading sign: '-' or '+' event while operand_has_digits=0 and pending=none sets entry sign (sgn_AUX=1 for '-', 0 for '+'). No execution.
- Op event with operand_has_digits=1:
  - If pending=none: ACC=signed AUX, then pending=op ('='→none), fresh=1.
  - Otherwise: start EXEC with ACC op AUX.
- '-' or '+' with pending set and no new digits: replaces pending only, no execution.
- Operand after an op starts positive.
- '=' with no pending: no-op.
- After '=': a digit event starts a new expression, discarding ACC. A +/- event uses the result as first operand.
- EXEC, signed-magnitude arithmetic:
  - The SUB op flips the operand sign. Equal effective signs → magnitude add, else magnitude subtract (ACC−AUX).
  - EXEC_A processes one digit per cycle, LSD first, DIGITS cycles.
  - Add: carry out of the top digit sets full_ACC=1; magnitude wraps mod 10^DIGITS.
  - Subtract: uses 9s-complement+1. A final borrow triggers EXEC_B, DIGITS cycles of 10s-complement, and flips the sign.
  - Result 0 → sign 0.
- busy is high for all EXEC_A/EXEC_B cycles. Latency from event cycle to done: DIGITS+2 cycles, or 2*DIGITS+2 with EXEC_B.
- WRITE: AUX, sgn_AUX and ACC take the result; done=1 for this single cycle; return to ENTRY with fresh=1.
- full_AUX clears on any accepted op event. full_ACC clears only on clear/reset. Overflowed results still load.
- digit and operation events in the same cycle: the op is processed, the digit is dropped.

Test Plan:
- Reset low mid-entry → all outputs 0 asynchronously. Press 4,6,+,7,0,= → AUX=0x116, sgn_AUX=0, done pulse after 12 cycles (DIGITS=10).
- '-',8,8,'-',2,1,2,= → AUX=0x300, sgn_AUX=1, full_ACC=0.
- 1,6,'-',1,8,5,= → EXEC_B taken, busy 20 cycles, AUX=0x169, sgn_AUX=1.
- '-',9,'+',5,6,4,= → AUX=0x555, sgn_AUX=0. Hold digit 5 for 5 cycles → single entry.
- Ten 9s then 4 → 4 rejected, full_AUX=1, AUX=0x9999999999. Then +,9,= → full_ACC=1, AUX=0x0000000008, full_AUX=0.
- During busy, press 7 and '+' → both ignored. clear_ALU asserted mid-EXEC → AUX=0, busy=0, no done pulse. Rerun DIGITS=4: 9999+1= → full_ACC=1, AUX=0x0000.
